// File: rtl/uart_cmd_responder.sv
// Byte-stream command responder: READ / WRITE / ECHO against a small register file.
// Defining UART_CMD_TIMEOUT_EN adds an inter-byte timeout; the default build waits forever.
module uart_cmd_responder #(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_DEPTH      = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy
);

    localparam int AW = $clog2(REG_DEPTH);
    localparam logic [DATA_WIDTH-1:0] OP_READ  = DATA_WIDTH'(8'h01);
    localparam logic [DATA_WIDTH-1:0] OP_WRITE = DATA_WIDTH'(8'h02);
    localparam logic [DATA_WIDTH-1:0] OP_ECHO  = DATA_WIDTH'(8'h03);
    localparam logic [DATA_WIDTH-1:0] RESP_ERR = DATA_WIDTH'(8'hEE);
    localparam logic [DATA_WIDTH-1:0] RESP_OK  = DATA_WIDTH'(8'hAA);

    typedef enum logic [1:0] {IDLE, GET_ADDR, GET_DATA, SEND} state_t;

    state_t                state;
    logic                  is_write;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] regs [REG_DEPTH];
    logic                  rx_fire;
    logic                  addr_bad;
    logic                  timed_out;

    assign rx_fire  = rx_valid && rx_ready;
    assign addr_bad = (rx_data >> AW) != '0;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] idle_cnt;

    assign timed_out = (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Counts cycles without a byte while mid-command; any handshake restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if ((state == GET_ADDR || state == GET_DATA) && !rx_fire && !timed_out)
            idle_cnt <= idle_cnt + 1'b1;
        else
            idle_cnt <= '0;
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            is_write <= 1'b0;
            addr     <= '0;
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        busy     <= 1'b1;
                        is_write <= (rx_data == OP_WRITE);
                        if (rx_data == OP_READ || rx_data == OP_WRITE) begin
                            state <= GET_ADDR;
                        end else if (rx_data == OP_ECHO) begin
                            state <= GET_DATA;
                        end else begin
                            state    <= SEND;
                            rx_ready <= 1'b0;
                            tx_valid <= 1'b1;
                            tx_data  <= RESP_ERR;
                        end
                    end
                end
                GET_ADDR: begin
                    if (rx_fire) begin
                        if (!addr_bad && is_write) begin
                            addr  <= rx_data[AW-1:0];
                            state <= GET_DATA;
                        end else begin
                            state    <= SEND;
                            rx_ready <= 1'b0;
                            tx_valid <= 1'b1;
                            tx_data  <= addr_bad ? RESP_ERR : regs[rx_data[AW-1:0]];
                        end
                    end else if (timed_out) begin
                        state    <= SEND;
                        rx_ready <= 1'b0;
                        tx_valid <= 1'b1;
                        tx_data  <= RESP_ERR;
                    end
                end
                GET_DATA: begin
                    if (rx_fire) begin
                        if (is_write) regs[addr] <= rx_data;
                        state    <= SEND;
                        rx_ready <= 1'b0;
                        tx_valid <= 1'b1;
                        tx_data  <= is_write ? RESP_OK : rx_data;
                    end else if (timed_out) begin
                        // A timed-out WRITE never touches the register file.
                        state    <= SEND;
                        rx_ready <= 1'b0;
                        tx_valid <= 1'b1;
                        tx_data  <= RESP_ERR;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        rx_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder; build with UART_CMD_TIMEOUT_EN to exercise the timeout path.
module tb_uart_cmd_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    uart_cmd_responder #(
        .DATA_WIDTH(8),
        .REG_DEPTH(16),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("rx_accept", rx_ready, 1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic get_resp(output logic [7:0] d);
        int w = 0;
        tx_ready = 1'b1;
        while (!tx_valid && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("tx_wait", tx_valid, 1);
        d = tx_data;
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int n;
        int stable;
        logic [7:0] stim [$];
        logic [7:0] exp_q [$];
        logic [7:0] got_q [$];

        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", rx_ready, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_data", tx_data, 0);
        rst = 1'b0;
        check("rx_ready_before_edge", rx_ready, 0);
        @(posedge clk); #1;
        check("rx_ready_after_rst", rx_ready, 1);

        send_byte(8'h02); send_byte(8'h05); send_byte(8'h3C);
        get_resp(d); check("write_ack", d, 8'hAA);
        send_byte(8'h01); send_byte(8'h05);
        get_resp(d); check("read_after_write", d, 8'h3C);
        send_byte(8'h01); send_byte(8'h07);
        get_resp(d); check("read_unwritten", d, 8'h00);

        // ECHO with the transmitter stalled for 10 cycles
        send_byte(8'h03); send_byte(8'h7F);
        check("echo_latency", tx_valid, 1);
        check("echo_busy", busy, 1);
        check("echo_rx_stalled", rx_ready, 0);
        stable = 1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!tx_valid || tx_data !== 8'h7F) stable = 0;
        end
        check("echo_stable", stable, 1);
        check("echo_data", tx_data, 8'h7F);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        n = 0;
        repeat (5) begin
            n += int'(tx_valid);
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        check("echo_single_transfer", n, 0);

        send_byte(8'h55);
        get_resp(d); check("bad_opcode", d, 8'hEE);
        check("bad_opcode_done", tx_valid, 0);
        check("bad_opcode_idle", busy, 0);
        send_byte(8'h01); send_byte(8'h20);
        get_resp(d); check("read_out_of_range", d, 8'hEE);
        send_byte(8'h02); send_byte(8'h15);
        get_resp(d); check("write_out_of_range", d, 8'hEE);
        send_byte(8'h01); send_byte(8'h05);
        get_resp(d); check("no_reg_change", d, 8'h3C);

        // Reset in the middle of a WRITE, then in the middle of SEND
        send_byte(8'h02); send_byte(8'h05);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midcmd_rst_busy", busy, 0);
        check("midcmd_rst_rx_ready", rx_ready, 0);
        rst = 1'b0;
        tx_ready = 1'b1;
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            n += int'(tx_valid);
        end
        tx_ready = 1'b0;
        check("midcmd_no_resp", n, 0);
        send_byte(8'h01); send_byte(8'h05);
        get_resp(d); check("midcmd_reg_cleared", d, 8'h00);

        send_byte(8'h03); send_byte(8'h44);
        check("send_pending", tx_valid, 1);
        rst = 1'b1;
        #1;
        check("midsend_rst_tx_valid", tx_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            n += int'(tx_valid);
        end
        tx_ready = 1'b0;
        check("midsend_no_resp", n, 0);

        // Back-to-back commands with rx_valid held high throughout
        stim  = '{8'h03, 8'h11, 8'h02, 8'h03, 8'h99, 8'h01, 8'h03, 8'h55};
        exp_q = '{8'h11, 8'hAA, 8'h99, 8'hEE};
        fork
            begin
                foreach (stim[i]) begin
                    int w = 0;
                    rx_data  = stim[i];
                    rx_valid = 1'b1;
                    while (!rx_ready && w < 200) begin
                        @(posedge clk); #1;
                        w++;
                    end
                    @(posedge clk); #1;
                end
                rx_valid = 1'b0;
            end
            begin
                int w = 0;
                tx_ready = 1'b1;
                while (got_q.size() < 4 && w < 400) begin
                    if (tx_valid) got_q.push_back(tx_data);
                    @(posedge clk); #1;
                    w++;
                end
                tx_ready = 1'b0;
            end
        join
        check("b2b_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check("b2b_resp", (i < got_q.size()) ? got_q[i] : 8'hXX, exp_q[i]);

`ifdef UART_CMD_TIMEOUT_EN
        send_byte(8'h01);
        n = 0;
        while (!tx_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_cycles", n, 50);
        check("timeout_resp", tx_data, 8'hEE);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        check("timeout_idle", busy, 0);
`else
        send_byte(8'h01);
        n = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            n += int'(tx_valid);
        end
        check("no_timeout_resp", n, 0);
        check("still_waiting", busy, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
